// File: rtl/scan_mux_pkg.sv
// Shared types for the scanning channel selector: FSM state encoding and mode pin values.
package scan_mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // The strobe overrides the mode pin.
  function automatic state_t decode_state(input logic en_n, input logic mode);
    if (en_n)
      decode_state = IDLE;
    else if (mode == MODE_SCAN)
      decode_state = SCAN;
    else
      decode_state = MANUAL;
  endfunction

endpackage

// File: rtl/scan_mux_reg_if.sv
// Pin bundle between the input pads and the display logic for the scanning selector.
interface scan_mux_reg_if #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
);
  logic [CHANNELS*WIDTH-1:0] D;
  logic [SEL_W-1:0]          Sel;
  logic                      Mode;
  logic                      En_n;
  logic [WIDTH-1:0]          Result;
  logic [SEL_W-1:0]          Cur_Sel;
  logic                      Valid;
  logic                      Wrap;

  modport master (
    output D, Sel, Mode, En_n,
    input  Result, Cur_Sel, Valid, Wrap
  );

  modport slave (
    input  D, Sel, Mode, En_n,
    output Result, Cur_Sel, Valid, Wrap
  );
endinterface

// File: rtl/scan_mux_ctrl.sv
// Select controller: FSM, dwell counter, current-channel register and wrap pulse.
// The state being entered this edge is also exported so the datapath stays in step.
module scan_mux_ctrl
  import scan_mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int DWELL    = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             i_en_n,
  input  logic             i_mode,
  input  logic [SEL_W-1:0] i_sel,
  output state_t           o_state_nxt,
  output logic [SEL_W-1:0] o_cur_sel,
  output logic [SEL_W-1:0] o_cur_sel_nxt,
  output logic             o_wrap
);

  localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_cur_sel;
  logic             r_wrap;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [SEL_W-1:0] w_cur_sel_nxt;
  logic             w_wrap_nxt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = decode_state(i_en_n, i_mode);
  end

  // A scan step only happens when SCAN was already the state; entering SCAN starts a fresh dwell.
  always_comb begin
    w_cur_sel_nxt = r_cur_sel;
    w_cnt_nxt     = '0;
    w_wrap_nxt    = 1'b0;
    case (w_state_nxt)
      MANUAL: w_cur_sel_nxt = i_sel;
      SCAN: begin
        if (r_state == SCAN) begin
          if (r_cnt == LAST_CNT) begin
            w_cnt_nxt = '0;
            if (r_cur_sel >= LAST_SEL) begin
              w_cur_sel_nxt = '0;
              w_wrap_nxt    = (r_cur_sel == LAST_SEL);
            end else begin
              w_cur_sel_nxt = r_cur_sel + SEL_W'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cnt     <= '0;
      r_cur_sel <= '0;
      r_wrap    <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_cur_sel <= w_cur_sel_nxt;
      r_wrap    <= w_wrap_nxt;
    end
  end

  assign o_state_nxt   = w_state_nxt;
  assign o_cur_sel     = r_cur_sel;
  assign o_cur_sel_nxt = w_cur_sel_nxt;
  assign o_wrap        = r_wrap;

endmodule

// File: rtl/scan_mux_reg.sv
// Registered CHANNELS:1 selector with manual and scanning modes and an active-low strobe.
// Result/Valid are loaded from the same next-select value the controller registers, so they never skew.
module scan_mux_reg
  import scan_mux_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int DWELL    = 4
) (
  input  logic           Clk,
  input  logic           Rst_n,
  scan_mux_reg_if.slave  bus
);

  state_t           w_state_nxt;
  logic [SEL_W-1:0] w_cur_sel;
  logic [SEL_W-1:0] w_cur_sel_nxt;
  logic             w_wrap;
  logic [WIDTH-1:0] w_chan;
  logic             w_hit;

  logic [WIDTH-1:0] r_result_p1;
  logic             r_vld_p1;

  scan_mux_ctrl #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W),
    .DWELL    (DWELL)
  ) u_ctrl (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .i_en_n        (bus.En_n),
    .i_mode        (bus.Mode),
    .i_sel         (bus.Sel),
    .o_state_nxt   (w_state_nxt),
    .o_cur_sel     (w_cur_sel),
    .o_cur_sel_nxt (w_cur_sel_nxt),
    .o_wrap        (w_wrap)
  );

  // Select codes beyond the last channel match nothing and yield a dead (zero, invalid) output.
  always_comb begin
    w_chan = '0;
    w_hit  = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_cur_sel_nxt == SEL_W'(k)) begin
        w_chan = bus.D[k*WIDTH +: WIDTH];
        w_hit  = 1'b1;
      end
    end
  end

  // Stage p1: registered output
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_result_p1 <= '0;
      r_vld_p1    <= 1'b0;
    end else if (w_state_nxt == IDLE || !w_hit) begin
      r_result_p1 <= '0;
      r_vld_p1    <= 1'b0;
    end else begin
      r_result_p1 <= w_chan;
      r_vld_p1    <= 1'b1;
    end
  end

  assign bus.Result  = r_result_p1;
  assign bus.Valid   = r_vld_p1;
  assign bus.Cur_Sel = w_cur_sel;
  assign bus.Wrap    = w_wrap;

endmodule

// File: tb/tb_scan_mux_reg.sv
// Bench for scan_mux_reg: a 4-channel/dwell-3 and a 3-channel/dwell-1 instance share the controls,
// with directed scenarios followed by random stimulus against a cycle-level reference model.
module tb_scan_mux_reg;

  logic        Clk = 1'b0;
  logic        rst_n;
  logic        en_n;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] da;
  logic [11:0] db;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  scan_mux_reg_if #(.WIDTH(4), .CHANNELS(4)) ifa ();
  scan_mux_reg_if #(.WIDTH(4), .CHANNELS(3)) ifb ();

  assign ifa.D    = da;
  assign ifa.Sel  = sel;
  assign ifa.Mode = mode;
  assign ifa.En_n = en_n;
  assign ifb.D    = db;
  assign ifb.Sel  = sel;
  assign ifb.Mode = mode;
  assign ifb.En_n = en_n;

  scan_mux_reg #(.WIDTH(4), .CHANNELS(4), .DWELL(3)) u_a (
    .Clk   (Clk),
    .Rst_n (rst_n),
    .bus   (ifa)
  );

  scan_mux_reg #(.WIDTH(4), .CHANNELS(3), .DWELL(1)) u_b (
    .Clk   (Clk),
    .Rst_n (rst_n),
    .bus   (ifb)
  );

  // Reference model: per instance, channel shown, how long it has been shown, and expected outputs.
  int CH[2] = '{4, 3};
  int DW[2] = '{3, 1};
  int m_prev[2];
  int m_cur[2];
  int m_held[2];
  int m_res[2];
  int m_vld[2];
  int m_wrap[2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_prev[i] = 0; m_cur[i] = 0; m_held[i] = 0;
      m_res[i]  = 0; m_vld[i] = 0; m_wrap[i] = 0;
    end
  endtask

  // ns: 0 = disabled, 1 = manual, 2 = scan
  task automatic model_step(input int i, input logic [31:0] d);
    int ns;
    ns = en_n ? 0 : (mode ? 2 : 1);
    m_wrap[i] = 0;
    if (ns == 1) begin
      m_cur[i]  = int'(sel);
      m_held[i] = 0;
    end else if (ns == 2) begin
      if (m_prev[i] == 2) begin
        if (m_held[i] >= DW[i]) begin
          m_wrap[i] = (m_cur[i] == CH[i] - 1) ? 1 : 0;
          m_cur[i]  = (m_cur[i] >= CH[i] - 1) ? 0 : m_cur[i] + 1;
          m_held[i] = 1;
        end else begin
          m_held[i]++;
        end
      end else begin
        m_held[i] = 1;
      end
    end else begin
      m_held[i] = 0;
    end
    if (ns == 0) begin
      m_res[i] = 0;
      m_vld[i] = 0;
    end else begin
      m_vld[i] = (m_cur[i] < CH[i]) ? 1 : 0;
      m_res[i] = m_vld[i] ? int'((d >> (4 * m_cur[i])) & 32'hF) : 0;
    end
    m_prev[i] = ns;
  endtask

  task automatic cmp_model();
    check_val("a_result",  32'(ifa.Result),  32'(m_res[0]));
    check_val("a_cur_sel", 32'(ifa.Cur_Sel), 32'(m_cur[0]));
    check_val("a_valid",   32'(ifa.Valid),   32'(m_vld[0]));
    check_val("a_wrap",    32'(ifa.Wrap),    32'(m_wrap[0]));
    check_val("b_result",  32'(ifb.Result),  32'(m_res[1]));
    check_val("b_cur_sel", 32'(ifb.Cur_Sel), 32'(m_cur[1]));
    check_val("b_valid",   32'(ifb.Valid),   32'(m_vld[1]));
    check_val("b_wrap",    32'(ifb.Wrap),    32'(m_wrap[1]));
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_step(0, 32'(da));
    model_step(1, 32'(db));
    #1;
    cmp_model();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    en_n  = 1'b1;
    mode  = 1'b0;
    sel   = 2'd0;
    da    = 16'hDCBA;
    db    = 12'h987;
    model_reset();
    #2;
    check_val("rst_a_result", 32'(ifa.Result),  32'h0);
    check_val("rst_a_cur",    32'(ifa.Cur_Sel), 32'h0);
    check_val("rst_a_valid",  32'(ifa.Valid),   32'h0);
    check_val("rst_a_wrap",   32'(ifa.Wrap),    32'h0);
    @(negedge Clk);
    rst_n = 1'b1;
    cycle();

    // Manual select
    en_n = 1'b0; mode = 1'b0; sel = 2'd2;
    cycle();
    check_val("man_sel2_result", 32'(ifa.Result), 32'hC);
    check_val("man_sel2_valid",  32'(ifa.Valid),  32'h1);
    sel = 2'd0;
    cycle();
    check_val("man_sel0_result", 32'(ifa.Result), 32'hA);

    // Scan timing from channel 0
    mode = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      cycle();
      check_val("scan_cur",    32'(ifa.Cur_Sel), 32'(((i - 1) / 3) % 4));
      check_val("scan_wrap",   32'(ifa.Wrap),    32'(i == 13));
      check_val("scan_result", 32'(ifa.Result),  32'(4'hA + ((i - 1) / 3) % 4));
    end

    // Strobe mid-dwell on channel 2
    n = 0;
    while (m_cur[0] != 2 && n < 20) begin
      cycle();
      n++;
    end
    check_val("wait_ch2", 32'(ifa.Cur_Sel), 32'h2);
    cycle();
    en_n = 1'b1;
    cycle();
    check_val("strobe_result", 32'(ifa.Result),  32'h0);
    check_val("strobe_valid",  32'(ifa.Valid),   32'h0);
    check_val("strobe_cur",    32'(ifa.Cur_Sel), 32'h2);
    en_n = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      cycle();
      check_val("resume_cur", 32'(ifa.Cur_Sel), (j <= 3) ? 32'h2 : 32'h3);
    end

    // Disable on the edge where 3->0 is due
    cycle();
    cycle();
    en_n = 1'b1;
    cycle();
    check_val("collide_wrap", 32'(ifa.Wrap),    32'h0);
    check_val("collide_cur",  32'(ifa.Cur_Sel), 32'h3);
    en_n = 1'b0; mode = 1'b0; sel = 2'd1;
    cycle();
    check_val("collide_manual_cur", 32'(ifa.Cur_Sel), 32'h1);

    // Out-of-range select on the 3-channel instance, then dwell-1 scanning
    sel = 2'd3;
    cycle();
    check_val("oor_result", 32'(ifb.Result),  32'h0);
    check_val("oor_valid",  32'(ifb.Valid),   32'h0);
    check_val("oor_cur",    32'(ifb.Cur_Sel), 32'h3);
    check_val("oor_a_ch3",  32'(ifa.Result),  32'hD);
    sel = 2'd0;
    cycle();
    mode = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      cycle();
      check_val("d1_cur",    32'(ifb.Cur_Sel), 32'((j - 1) % 3));
      check_val("d1_wrap",   32'(ifb.Wrap),    32'(j == 4));
      check_val("d1_result", 32'(ifb.Result),  32'((db >> (4 * ((j - 1) % 3))) & 12'hF));
    end

    // Random stimulus against the model
    for (int t = 0; t < 600; t++) begin
      da = 16'($urandom);
      db = 12'($urandom);
      sel = 2'($urandom_range(0, 3));
      en_n = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0)
        mode = ~mode;
      cycle();
    end

    // Asynchronous reset in the middle of a scan, away from any clock edge
    en_n = 1'b0; mode = 1'b1; da = 16'hDCBA;
    for (int j = 0; j < 5; j++)
      cycle();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("arst_a_result", 32'(ifa.Result),  32'h0);
    check_val("arst_a_cur",    32'(ifa.Cur_Sel), 32'h0);
    check_val("arst_a_valid",  32'(ifa.Valid),   32'h0);
    check_val("arst_a_wrap",   32'(ifa.Wrap),    32'h0);
    check_val("arst_b_cur",    32'(ifb.Cur_Sel), 32'h0);
    check_val("arst_b_valid",  32'(ifb.Valid),   32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
